// File: rtl/cordic_cos_iter_param.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_cos_iter_param
//  Description : Iterative CORDIC cosine (and optional sine) unit for a
//                multi-cycle custom-instruction slot. An FP32 angle becomes
//                W-bit signed fixed point, ITER micro-rotations run one per
//                enabled cycle, and the results are converted back to FP32.
//                Optional build macro: CORDIC_SIN_EN (adds result_sin).
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_cos_iter_param #(
    parameter int W    = 22,
    parameter int ITER = 16
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done
`ifdef CORDIC_SIN_EN
    ,
    output logic [31:0] result_sin
`endif
);

    localparam int FRAC = W - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_CONV = 2'd2
    } state_t;

    // atan(2^-i) * 2^30, i = 0..31
    localparam logic [31:0] c_atan30 [32] = '{
        32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
        32'h03FEAB77, 32'h01FFD55B, 32'h00FFFAAB, 32'h007FFF55,
        32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
        32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
        32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
        32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080,
        32'h00000040, 32'h00000020, 32'h00000010, 32'h00000008,
        32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
    };

    // CORDIC gain compensation 1/prod(sqrt(1+2^-2i)) scaled by 2^FRAC
    function automatic logic [W-1:0] f_gain();
        real k2;
        real p;
        real r;
        real s;
        k2 = 1.0;
        p  = 1.0;
        for (int i = 0; i < ITER; i++) begin
            k2 = k2 / (1.0 + p * p);
            p  = p / 2.0;
        end
        r = 1.0;
        for (int n = 0; n < 40; n++) begin
            r = 0.5 * (r + k2 / r);
        end
        s = 1.0;
        for (int n = 0; n < FRAC; n++) begin
            s = s * 2.0;
        end
        return W'($rtoi(r * s + 0.5));
    endfunction

    localparam logic [W-1:0] c_k = f_gain();

    // Signed fixed point to FP32: leading-one normalise, mantissa truncated
    function automatic logic [31:0] f_to_fp32(input logic [W-1:0] v);
        logic [W-1:0] mag;
        logic [7:0]   e;
        logic [22:0]  m;
        int           p;
        mag = v[W-1] ? (~v + W'(1)) : v;
        p   = 0;
        for (int b = 0; b < W; b++) begin
            if (mag[b]) p = b;
        end
        e = 8'(127 + p - FRAC);
        m = 23'((64'(mag) << (63 - p)) >> 40);
        if (v == '0) f_to_fp32 = 32'h0;
        else         f_to_fp32 = {v[W-1], e, m};
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic signed [W-1:0]   r_x;
    logic signed [W-1:0]   r_y;
    logic signed [W-1:0]   r_z;
    logic [4:0]            r_iter;
    logic [31:0]           r_result;
    logic                  r_done;
`ifdef CORDIC_SIN_EN
    logic [31:0]           r_result_sin;
`endif

    logic signed [W-1:0]   w_atan_rom [32];
    logic signed [W-1:0]   w_atan;
    logic signed [W-1:0]   w_x_sh;
    logic signed [W-1:0]   w_y_sh;
    logic                  w_dir_pos;
    logic                  w_sign;
    logic [7:0]            w_exp;
    logic [22:0]           w_mant;
    logic [8:0]            w_shamt;
    logic [W-1:0]          w_mag_in;
    logic signed [W-1:0]   w_z_in;

    // Angle table rescaled from 30 to FRAC fractional bits
    for (genvar g = 0; g < 32; g++) begin : g_atan
        assign w_atan_rom[g] = W'(c_atan30[g] >> (30 - FRAC));
    end

    // Operands for the current micro-rotation
    assign w_dir_pos = ~r_z[W-1];
    assign w_x_sh    = r_x >>> r_iter;
    assign w_y_sh    = r_y >>> r_iter;
    assign w_atan    = w_atan_rom[r_iter];

    // FP32 input fields; shift folds the exponent and the 23-bit mantissa scale
    assign w_sign  = dataa[31];
    assign w_exp   = dataa[30:23];
    assign w_mant  = dataa[22:0];
    assign w_shamt = 9'd150 - {1'b0, w_exp};

    // FP32 angle to signed fixed point: zero, clamp below 1.0, or shift and truncate
    always_comb begin
        w_mag_in = '0;
        if (w_exp == 8'd0) begin
            w_mag_in = '0;
        end else if (w_exp >= 8'd127) begin
            w_mag_in = W'((64'd1 << FRAC) - 64'd1);
        end else begin
            w_mag_in = W'(({40'd0, 1'b1, w_mant} << FRAC) >> w_shamt);
        end
        w_z_in = w_sign ? -$signed(w_mag_in) : $signed(w_mag_in);
    end

    // State register; reset wins over the clock enable
    always_ff @(posedge clock) begin
        if (aclr) begin
            r_state <= S_IDLE;
        end else if (clk_en) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a start is only honoured from IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_iter == 5'(ITER - 1)) w_state_nxt = S_CONV;
            S_CONV:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Rotation datapath: seed on start, one micro-rotation per RUN cycle
    always_ff @(posedge clock) begin
        if (aclr) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_iter <= '0;
        end else if (clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x    <= c_k;
                        r_y    <= '0;
                        r_z    <= w_z_in;
                        r_iter <= '0;
                    end
                end
                S_RUN: begin
                    if (w_dir_pos) begin
                        r_x <= r_x - w_y_sh;
                        r_y <= r_y + w_x_sh;
                        r_z <= r_z - w_atan;
                    end else begin
                        r_x <= r_x + w_y_sh;
                        r_y <= r_y - w_x_sh;
                        r_z <= r_z + w_atan;
                    end
                    r_iter <= r_iter + 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Output registers: loaded in CONV and held otherwise; done lasts one enabled cycle
    always_ff @(posedge clock) begin
        if (aclr) begin
            r_result     <= '0;
            r_done       <= 1'b0;
`ifdef CORDIC_SIN_EN
            r_result_sin <= '0;
`endif
        end else if (clk_en) begin
            r_done <= (r_state == S_CONV);
            if (r_state == S_CONV) begin
                r_result     <= f_to_fp32(r_x);
`ifdef CORDIC_SIN_EN
                r_result_sin <= f_to_fp32(r_y);
`endif
            end
        end
    end

    assign result = r_result;
    assign done   = r_done;
`ifdef CORDIC_SIN_EN
    assign result_sin = r_result_sin;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cordic_cos_iter_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_cos_iter_param
//  Description : Directed self-checking bench for cordic_cos_iter_param
//                (default W=22, ITER=16). Sine checks are active when the
//                CORDIC_SIN_EN macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_cos_iter_param;

    localparam int LAT_LIMIT = 60;
    // Sixteen micro-rotations leave up to atan(2^-15) of residual angle, and
    // every shift truncates; near 1.0 that is several hundred FP32 ulps, so
    // tolerances are set at that scale while still rejecting gross errors.
    localparam int TOL = 1024;

    logic        clock;
    logic        aclr;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] result;
    logic        done;
`ifdef CORDIC_SIN_EN
    logic [31:0] result_sin;
`endif

    int n_checks = 0;
    int n_errors = 0;

    cordic_cos_iter_param #(
        .W    (22),
        .ITER (16)
    ) dut (
        .clock      (clock),
        .aclr       (aclr),
        .clk_en     (clk_en),
        .start      (start),
        .dataa      (dataa),
        .result     (result),
        .done       (done)
`ifdef CORDIC_SIN_EN
        ,
        .result_sin (result_sin)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare an FP32 (or plain) value within tol units of the last place
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp, input int tol);
        longint diff;
        n_checks++;
        if (got[31] !== exp[31]) begin
            diff = 64'h7FFF_FFFF;
        end else begin
            diff = longint'(got[30:0]) - longint'(exp[30:0]);
            if (diff < 0) diff = -diff;
        end
        if ($isunknown(got) || diff > longint'(tol)) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (+-%0d)", tag, got, exp, tol);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input logic [31:0] a);
        dataa = a;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // mode 0: plain; 1: clk_en low for five edges; 2: start pulsed again mid-run
    task automatic wait_done(input int mode, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < LAT_LIMIT) begin
            step();
            lat++;
            if (mode == 1 && lat == 5)  clk_en = 1'b0;
            if (mode == 1 && lat == 10) clk_en = 1'b1;
            if (mode == 2 && lat == 3)  start  = 1'b1;
            if (mode == 2 && lat == 4)  start  = 1'b0;
        end
    endtask

    task automatic run_case(input string tag, input logic [31:0] a, input int mode,
                            input int exp_lat, input logic [31:0] exp_cos,
                            input logic [31:0] exp_sin, input bit chk_sin, input int tol);
        int lat;
        launch(a);
        wait_done(mode, lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat), 0);
        check({tag, " cos"}, result, exp_cos, tol);
`ifdef CORDIC_SIN_EN
        if (chk_sin) check({tag, " sin"}, result_sin, exp_sin, tol);
`else
        if (chk_sin && exp_sin === 32'hx) $display("note: %s", tag);
`endif
    endtask

    initial begin
        int n_done;
        aclr   = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = 32'h0;

        for (int k = 0; k < 3; k++) begin
            step();
            check("reset done", 32'(done), 32'h0, 0);
            check("reset result", result, 32'h0, 0);
        end
        aclr = 1'b0;
        step();

        // cos(0.5), then done and result held while the enable is low
        run_case("a=0.5", 32'h3F000000, 0, 17, 32'h3F60A940, 32'h3EF57744, 1'b1, TOL);
        clk_en = 1'b0;
        step();
        step();
        check("held done", 32'(done), 32'h1, 0);
        check("held result", result, 32'h3F60A940, TOL);
        clk_en = 1'b1;
        step();
        check("done single pulse", 32'(done), 32'h0, 0);
        check("result kept", result, 32'h3F60A940, TOL);
        step();

        run_case("a=-0.5", 32'hBF000000, 0, 17, 32'h3F60A940, 32'hBEF57744, 1'b1, TOL);
        step();
        run_case("a=0", 32'h00000000, 0, 17, 32'h3F800000, 32'h0, 1'b0, TOL);
        step();
        run_case("a=-denorm", 32'h80000001, 0, 17, 32'h3F800000, 32'h0, 1'b0, TOL);
        step();
        // Both clamp to magnitude 1.0-2^-20: cos(1)=0.540302, sin(1)=0.841471
        run_case("a=1.5", 32'h3FC00000, 0, 17, 32'h3F0A5140, 32'h3F576AA4, 1'b1, 2 * TOL);
        step();
        run_case("a=-2.0", 32'hC0000000, 0, 17, 32'h3F0A5140, 32'hBF576AA4, 1'b1, 2 * TOL);
        step();

        run_case("clk_en gap", 32'h3F000000, 1, 22, 32'h3F60A940, 32'h3EF57744, 1'b1, TOL);
        step();

        run_case("restart", 32'h3F000000, 2, 17, 32'h3F60A940, 32'h3EF57744, 1'b1, TOL);
        n_done = 0;
        for (int c = 0; c < 25; c++) begin
            step();
            if (done === 1'b1) n_done++;
        end
        check("restart extra done", 32'(n_done), 32'h0, 0);

        // Abort mid-run: no done, outputs cleared
        launch(32'h3F000000);
        n_done = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (c == 8) aclr = 1'b1;
            if (c == 9) aclr = 1'b0;
            if (done === 1'b1) n_done++;
        end
        check("abort done count", 32'(n_done), 32'h0, 0);
        check("abort result", result, 32'h0, 0);

        run_case("after abort", 32'h3F000000, 0, 17, 32'h3F60A940, 32'h3EF57744, 1'b1, TOL);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
